// File: rtl/tx_frame_buf_pkg.sv
// Shared constants and state encoding for the ping-pong transmit payload buffer.
package tx_frame_buf_pkg;

    localparam int FRAME_BYTES = 1024;
    localparam int OFF_AW      = 10;
    localparam int BUF_AW      = 11;
    localparam int IFG_CYC     = 12;
    localparam int ARM_TIMEOUT = 16;
    localparam int IDLE_W      = 5;
    localparam int ARM_W       = 5;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } buf_state_e;

endpackage

// File: rtl/tx_frame_buf_if.sv
// Stream-in and transmitter-side signals of the payload buffer.
interface tx_frame_buf_if;
    import tx_frame_buf_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              idx;
    logic [BUF_AW-1:0] txad;
    logic              txctl;
    logic [7:0]        data1;

    modport slave (
        input  s_data, s_valid, txad, txctl,
        output s_ready, idx, data1
    );

    modport master (
        output s_data, s_valid, txad, txctl,
        input  s_ready, idx, data1
    );

endinterface

// File: rtl/tx_frame_buf_sdp_ram.sv
// Simple dual-port 2048x8 RAM: one write port, one registered read port, no reset.
module sdp_ram_2k8
    import tx_frame_buf_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [BUF_AW-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<BUF_AW)-1];

    // Read returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tx_frame_buf.sv
// Ping-pong payload buffer: packs a byte stream into 1024-byte halves and hands each
// full half to the RGMII transmitter by toggling idx, respecting the inter-frame gap.
module tx_frame_buf
    import tx_frame_buf_pkg::*;
(
    input  logic                clk125,
    input  logic                rst_n,
    tx_frame_buf_if.slave       bus,
    output logic [OFF_AW-1:0]   wr_cnt,
    output logic [15:0]         frames,
    output logic                arm_err
);

    buf_state_e        state_q, state_d;
    logic              idx_q, idx_d;
    logic              s_ready_q, s_ready_d;
    logic [OFF_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [15:0]       frames_q, frames_d;
    logic              pending_q, pending_d;
    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic              arm_err_q, arm_err_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              rd_vld_q;

    logic              accept;
    logic              ifg_ok;
    logic              toggle;
    logic [7:0]        ram_rdata;

    assign accept = s_ready_q & bus.s_valid;
    // The current sample must also be idle so a toggle can never land on a txctl-high cycle.
    assign ifg_ok = (idle_cnt_q >= IDLE_W'(IFG_CYC)) & ~bus.txctl;
    assign toggle = (state_q == FULL) & ~pending_q & ifg_ok;

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            wr_cnt_q   <= '0;
            frames_q   <= '0;
            pending_q  <= 1'b0;
            arm_cnt_q  <= '0;
            arm_err_q  <= 1'b0;
            idle_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s_ready_q  <= s_ready_d;
            wr_cnt_q   <= wr_cnt_d;
            frames_q   <= frames_d;
            pending_q  <= pending_d;
            arm_cnt_q  <= arm_cnt_d;
            arm_err_q  <= arm_err_d;
            idle_cnt_q <= idle_cnt_d;
            rd_vld_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_cnt_d = wr_cnt_q;
        frames_d = frames_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == OFF_AW'(FRAME_BYTES - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (toggle) begin
                    idx_d    = ~idx_q;
                    frames_d = frames_q + 16'd1;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        s_ready_d = (state_d == FILL);
    end

    // Inter-frame gap tracking: consecutive txctl-low samples, saturating.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (bus.txctl) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != {IDLE_W{1'b1}}) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pending_d = pending_q;
        arm_cnt_d = arm_cnt_q;
        arm_err_d = arm_err_q;
        if (toggle) begin
            pending_d = 1'b1;
            arm_cnt_d = '0;
        end else if (pending_q) begin
            if (bus.txctl) begin
                pending_d = 1'b0;
            end else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1)) begin
                // Transmitter never started: give up waiting so the next half is not stuck.
                pending_d = 1'b0;
                arm_err_d = 1'b1;
                arm_cnt_d = ARM_W'(ARM_TIMEOUT);
            end else begin
                arm_cnt_d = arm_cnt_q + 1'b1;
            end
        end
    end

    sdp_ram_2k8 u_ram (
        .clk   (clk125),
        .we    (accept),
        .waddr ({~idx_q, wr_cnt_q}),
        .wdata (bus.s_data),
        .raddr (bus.txad),
        .rdata (ram_rdata)
    );

    // RAM output has no reset; gate it so data1 reads zero until the first post-reset edge.
    assign bus.data1   = rd_vld_q ? ram_rdata : 8'd0;
    assign bus.s_ready = s_ready_q;
    assign bus.idx     = idx_q;
    assign wr_cnt      = wr_cnt_q;
    assign frames      = frames_q;
    assign arm_err     = arm_err_q;

endmodule

// File: tb/tb_tx_frame_buf.sv
// Randomised self-checking bench for tx_frame_buf against a cycle-level behavioural model.
module tb_tx_frame_buf;
    import tx_frame_buf_pkg::*;

    logic        clk125 = 1'b0;
    logic        rst_n;
    logic [9:0]  wr_cnt;
    logic [15:0] frames;
    logic        arm_err;

    always #4 clk125 = ~clk125;

    tx_frame_buf_if bus();

    tx_frame_buf dut (
        .clk125  (clk125),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_cnt  (wr_cnt),
        .frames  (frames),
        .arm_err (arm_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_mem [2048];
    bit         m_vld [2048];
    bit         m_idx, m_ready, m_full, m_pending, m_err;
    int         m_fill, m_frames;
    int         edge_n, last_high, toggle_edge;
    logic [7:0] m_data1;
    bit         m_data1_known;

    // Stimulus / transmitter emulation
    int         fr_start = -1, fr_len = 1052, tx_delay = 4, prev_fall = 0;
    bit         fr_half;
    int         txctl_force = -1, txad_ovr = -1, sv_pct = 100, push_left = 0;
    bit         seq_data, rand_tx, track_first;
    int         acc_total = 0, first_byte = 0, dut_tog_edge = 0;
    logic       prev_dut_idx = 1'b0;
    logic [7:0] hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_ready = 0; m_full = 0; m_pending = 0; m_err = 0;
        m_fill = 0; m_frames = 0; edge_n = 0; last_high = -1; toggle_edge = -100;
        m_data1 = 8'd0; m_data1_known = 1;
    endtask

    task automatic on_toggle(input int t_edge);
        if (rand_tx) begin
            tx_delay = $urandom_range(1, 24);
            fr_len   = $urandom_range(100, 1100);
        end
        prev_fall = fr_start + fr_len;
        if (tx_delay >= 0) begin
            fr_start = t_edge + tx_delay;
            fr_half  = m_idx;
        end
    endtask

    task automatic model_step();
        logic [10:0] a;
        logic [10:0] ra;
        bit tog;
        ra = bus.txad;
        m_data1_known = m_vld[ra];
        m_data1 = m_mem[ra];
        tog = m_full && !m_pending && !bus.txctl && (edge_n - last_high >= IFG_CYC + 1);
        if (m_ready && bus.s_valid) begin
            a = {~m_idx, 10'(m_fill)};
            m_mem[a] = bus.s_data;
            m_vld[a] = 1;
            hist.push_back(bus.s_data);
            if (track_first) begin
                first_byte = bus.s_data;
                track_first = 0;
            end
            acc_total++;
            push_left--;
            m_fill++;
            if (m_fill == FRAME_BYTES) begin
                m_fill = 0;
                m_full = 1;
            end
        end
        if (tog) begin
            m_idx = ~m_idx;
            m_frames = (m_frames + 1) & 16'hFFFF;
            m_full = 0;
            m_pending = 1;
            toggle_edge = edge_n;
        end else if (m_pending) begin
            if (bus.txctl) m_pending = 0;
            else if (edge_n - toggle_edge >= ARM_TIMEOUT) begin
                m_pending = 0;
                m_err = 1;
            end
        end
        if (bus.txctl) last_high = edge_n;
        m_ready = !m_full;
        if (tog) on_toggle(edge_n);
        edge_n++;
    endtask

    task automatic drive();
        bit in_fr;
        in_fr = (fr_start >= 0) && (edge_n >= fr_start) && (edge_n < fr_start + fr_len);
        bus.txctl = (txctl_force >= 0) ? (txctl_force != 0) : in_fr;
        if (txad_ovr >= 0) bus.txad = 11'(txad_ovr);
        else if (in_fr) bus.txad = {fr_half, 10'(edge_n - fr_start)};
        else bus.txad = 11'($urandom_range(0, 2047));
        bus.s_valid = (push_left > 0) && ($urandom_range(0, 99) < sv_pct);
        bus.s_data = seq_data ? 8'(acc_total) : 8'($urandom);
    endtask

    task automatic check_all();
        chk("s_ready", bus.s_ready, m_ready);
        chk("idx", bus.idx, m_idx);
        chk("wr_cnt", wr_cnt, m_fill);
        chk("frames", frames, m_frames);
        chk("arm_err", arm_err, m_err);
        if (m_data1_known) chk("data1", bus.data1, m_data1);
        if (bus.idx !== prev_dut_idx) dut_tog_edge = edge_n - 1;
        prev_dut_idx = bus.idx;
    endtask

    task automatic cycle();
        drive();
        @(posedge clk125);
        model_step();
        @(negedge clk125);
        check_all();
    endtask

    // Called at a negedge; asserts reset asynchronously and checks outputs before any clock edge.
    task automatic apply_reset();
        push_left = 0; fr_start = -1; txctl_force = -1; txad_ovr = -1;
        bus.s_valid = 1'b1;
        bus.s_data = 8'h3C;
        bus.txctl = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_idx", bus.idx, 0);
        chk("rst_frames", frames, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_arm_err", arm_err, 0);
        chk("rst_data1", bus.data1, 0);
        model_reset();
        prev_dut_idx = 1'b0;
        repeat (3) @(posedge clk125);
        @(negedge clk125);
        chk("rst_hold_s_ready", bus.s_ready, 0);
        chk("rst_hold_wr_cnt", wr_cnt, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int f0;
        logic t4_idx;
        int release_edge;
        rst_n = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.txctl = 1'b0; bus.txad = '0;
        model_reset();

        // Reset with s_valid held high
        @(negedge clk125);
        apply_reset();
        cycle();
        chk("t1_ready_after_release", bus.s_ready, 1);

        // Sequential fill of one half, transmitter idle
        seq_data = 1; tx_delay = 4; fr_len = 1052; push_left = 1024;
        for (int i = 0; i < 3000 && m_idx == 0; i++) cycle();
        chk("t2_idx", bus.idx, 1);
        chk("t2_frames", frames, 1);
        chk("t2_ready_after_toggle", bus.s_ready, 1);
        txad_ovr = {1'b1, 10'd5};
        cycle();
        chk("t2_rd_h1_off5", bus.data1, 8'd5);
        txad_ovr = -1;
        repeat (1100) cycle();

        // Back-to-back 2048 bytes; second half waits for frame end plus gap
        seq_data = 0; hist.delete(); push_left = 2048; f0 = m_frames;
        for (int i = 0; i < 6000 && !(push_left == 0 && m_frames == f0 + 2); i++) cycle();
        chk("t3_frames", frames, f0 + 2);
        chk("t3_ifg_gap", dut_tog_edge - prev_fall, IFG_CYC);
        repeat (1100) cycle();
        for (int j = 0; j < 2048; j++) begin
            txad_ovr = {(j < 1024) ? ~m_idx : m_idx, 10'(j)};
            cycle();
            if (j < hist.size()) chk("t3_readback", bus.data1, hist[j]);
        end
        txad_ovr = -1;

        // Toggle guard: txctl held high while half fills
        txctl_force = 1; push_left = 1024;
        for (int i = 0; i < 1500 && !m_full; i++) cycle();
        t4_idx = bus.idx;
        repeat (40) cycle();
        chk("t4_idx_hold", bus.idx, t4_idx);
        chk("t4_ready_low", bus.s_ready, 0);
        release_edge = edge_n;
        txctl_force = -1;
        for (int i = 0; i < 100 && bus.idx == t4_idx; i++) cycle();
        chk("t4_gap", dut_tog_edge - release_edge, IFG_CYC);
        repeat (1100) cycle();

        // Timeout: transmitter never raises txctl
        chk("t5_err_before", arm_err, 0);
        tx_delay = -1; push_left = 2048; f0 = m_frames;
        for (int i = 0; i < 4000 && m_frames != f0 + 2; i++) cycle();
        chk("t5_arm_err", arm_err, 1);
        chk("t5_frames", frames, f0 + 2);
        repeat (20) cycle();
        chk("t5_arm_err_sticky", arm_err, 1);

        // Mid-operation reset at wr_cnt=500
        tx_delay = 4; push_left = 100000;
        for (int i = 0; i < 2000 && m_fill != 500; i++) cycle();
        chk("t6_wr_cnt_500", wr_cnt, 500);
        apply_reset();
        track_first = 1; push_left = 1;
        repeat (3) cycle();
        txad_ovr = {1'b1, 10'd0};
        cycle();
        chk("t6_refill_h1a0", bus.data1, first_byte);
        txad_ovr = -1;

        // Random traffic and transmitter timing
        rand_tx = 1; sv_pct = 60; push_left = 100000;
        repeat (8000) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
